// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and constants; OPFETCH_PC_READ_EN selects r15-reads-PC+8
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int PC_READ_OFFSET = 8;

`ifdef OPFETCH_PC_READ_EN
  localparam bit PC_READ_EN = 1'b1;
`else
  localparam bit PC_READ_EN = 1'b0;
`endif

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode/regfile/write-back/execute signals of the operand fetch stage
interface operand_fetch_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rn;
  logic [REG_AW-1:0] in_rm;
  logic [DATA_W-1:0] in_pc;
  logic [REG_AW-1:0] rf_read_regA;
  logic [REG_AW-1:0] rf_read_regB;
  logic [DATA_W-1:0] rf_data_regA;
  logic [DATA_W-1:0] rf_data_regB;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_opA;
  logic [DATA_W-1:0] out_opB;
  logic [REG_AW-1:0] out_rn;
  logic [REG_AW-1:0] out_rm;
  logic [DATA_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_rn, in_rm, in_pc, rf_data_regA, rf_data_regB,
           wb_en, wb_reg, wb_data, out_ready,
    output in_ready, rf_read_regA, rf_read_regB,
           out_valid, out_opA, out_opB, out_rn, out_rm, out_pc
  );

  modport master (
    output in_valid, in_rn, in_rm, in_pc, rf_data_regA, rf_data_regB,
           wb_en, wb_reg, wb_data, out_ready,
    input  in_ready, rf_read_regA, rf_read_regB,
           out_valid, out_opA, out_opB, out_rn, out_rm, out_pc
  );

endinterface

// File: rtl/opfetch_fwd_mux.sv
// rtl/opfetch_fwd_mux.sv - per-port operand select: PC+8, forwarded write-back, or regfile data
module opfetch_fwd_mux
  import cpu_pkg::*;
#(
  parameter int OP_W  = DATA_W,
  parameter int IDX_W = REG_AW
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OP_W-1:0]  pc_i,
  input  logic             fwd_en_i,
  input  logic [IDX_W-1:0] fwd_reg_i,
  input  logic [OP_W-1:0]  fwd_data_i,
  input  logic [OP_W-1:0]  rf_data_i,
  output logic [OP_W-1:0]  op_o
);

  always_comb begin
    op_o = rf_data_i;
    if (PC_READ_EN && idx_i == IDX_W'(REG_PC)) begin
      op_o = pc_i + OP_W'(PC_READ_OFFSET);
    end else if (fwd_en_i && fwd_reg_i == idx_i) begin
      // regfile data predates last cycle's write; the forward register holds that write
      op_o = fwd_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: S1 read issue, S2 output register, forwarding and snoop
module operand_fetch #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.slave  bus
);
  import cpu_pkg::*;

  logic              s1_valid_q, s1_valid_d;
  logic [REG_AW-1:0] s1_rn_q, s1_rn_d;
  logic [REG_AW-1:0] s1_rm_q, s1_rm_d;
  logic [DATA_W-1:0] s1_pc_q, s1_pc_d;

  logic              fwd_en_q;
  logic [REG_AW-1:0] fwd_reg_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_opA_q, out_opA_d;
  logic [DATA_W-1:0] out_opB_q, out_opB_d;
  logic [REG_AW-1:0] out_rn_q, out_rn_d;
  logic [REG_AW-1:0] out_rm_q, out_rm_d;
  logic [DATA_W-1:0] out_pc_q, out_pc_d;

  logic              s1_adv;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] s1_opA, s1_opB;

  assign s1_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !reset && (!s1_valid_q || s1_adv);
  assign accept   = bus.in_valid && in_ready;

  // A held S1 keeps re-reading its own registers so stalled operands stay current
  assign bus.rf_read_regA = (s1_valid_q && !s1_adv) ? s1_rn_q : bus.in_rn;
  assign bus.rf_read_regB = (s1_valid_q && !s1_adv) ? s1_rm_q : bus.in_rm;

  opfetch_fwd_mux #(.OP_W(DATA_W), .IDX_W(REG_AW)) u_mux_a (
    .idx_i      (s1_rn_q),
    .pc_i       (s1_pc_q),
    .fwd_en_i   (fwd_en_q),
    .fwd_reg_i  (fwd_reg_q),
    .fwd_data_i (fwd_data_q),
    .rf_data_i  (bus.rf_data_regA),
    .op_o       (s1_opA)
  );

  opfetch_fwd_mux #(.OP_W(DATA_W), .IDX_W(REG_AW)) u_mux_b (
    .idx_i      (s1_rm_q),
    .pc_i       (s1_pc_q),
    .fwd_en_i   (fwd_en_q),
    .fwd_reg_i  (fwd_reg_q),
    .fwd_data_i (fwd_data_q),
    .rf_data_i  (bus.rf_data_regB),
    .op_o       (s1_opB)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_rn_d     = s1_rn_q;
    s1_rm_d     = s1_rm_q;
    s1_pc_d     = s1_pc_q;
    out_valid_d = out_valid_q;
    out_opA_d   = out_opA_q;
    out_opB_d   = out_opB_q;
    out_rn_d    = out_rn_q;
    out_rm_d    = out_rm_q;
    out_pc_d    = out_pc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_rn_d    = bus.in_rn;
      s1_rm_d    = bus.in_rm;
      s1_pc_d    = bus.in_pc;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_valid_q && s1_adv) begin
      out_valid_d = 1'b1;
      out_opA_d   = s1_opA;
      out_opB_d   = s1_opB;
      out_rn_d    = s1_rn_q;
      out_rm_d    = s1_rm_q;
      out_pc_d    = s1_pc_q;
    end else if (s1_adv) begin
      out_valid_d = 1'b0;
    end else if (bus.wb_en) begin
      // S2 is stalled: snoop write-backs so execute sees current values
      if (bus.wb_reg == out_rn_q && !(PC_READ_EN && out_rn_q == REG_AW'(REG_PC)))
        out_opA_d = bus.wb_data;
      if (bus.wb_reg == out_rm_q && !(PC_READ_EN && out_rm_q == REG_AW'(REG_PC)))
        out_opB_d = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_rn_q     <= '0;
      s1_rm_q     <= '0;
      s1_pc_q     <= '0;
      fwd_en_q    <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_opA_q   <= '0;
      out_opB_q   <= '0;
      out_rn_q    <= '0;
      out_rm_q    <= '0;
      out_pc_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rn_q     <= s1_rn_d;
      s1_rm_q     <= s1_rm_d;
      s1_pc_q     <= s1_pc_d;
      fwd_en_q    <= bus.wb_en;
      fwd_reg_q   <= bus.wb_reg;
      fwd_data_q  <= bus.wb_data;
      out_valid_q <= out_valid_d;
      out_opA_q   <= out_opA_d;
      out_opB_q   <= out_opB_d;
      out_rn_q    <= out_rn_d;
      out_rm_q    <= out_rm_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_opA   = out_opA_q;
  assign bus.out_opB   = out_opB_q;
  assign bus.out_rn    = out_rn_q;
  assign bus.out_rm    = out_rm_q;
  assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch with a one-cycle-latency regfile model
module tb_operand_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(32), .REG_AW(4)) bus ();

  operand_fetch #(.DATA_W(32), .REG_AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Register file: registered read, write at the clock edge
  logic [31:0] rf [16];
  always @(posedge clk) begin
    bus.rf_data_regA <= rf[bus.rf_read_regA];
    bus.rf_data_regB <= rf[bus.rf_read_regB];
    if (bus.wb_en) rf[bus.wb_reg] <= bus.wb_data;
  end

  typedef struct {
    logic [3:0]  rn, rm;
    logic [31:0] pc;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, pc;
    logic [3:0]  rn, rm;
  } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  exp_t mon_e;
  int   out_cyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h expected no output", bus.out_pc);
      end else begin
        mon_e = sbq.pop_front();
        check("out_opA", bus.out_opA, mon_e.a);
        check("out_opB", bus.out_opB, mon_e.b);
        check("out_pc", bus.out_pc, mon_e.pc);
        check("out_rn", 32'(bus.out_rn), 32'(mon_e.rn));
        check("out_rm", 32'(bus.out_rm), 32'(mon_e.rm));
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] rn, input logic [3:0] rm, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a; e.b = b; e.pc = pc; e.rn = rn; e.rm = rm;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_rn = '0; bus.in_rm = '0; bus.in_pc = '0;
    bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.out_ready = 1'b0;

    // Preload via the write-back port while the stage is held in reset
    for (int i = 0; i < 16; i++) begin
      step();
      bus.wb_en = 1'b1; bus.wb_reg = 4'(i);
      bus.wb_data = (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : (32'hA000_0000 | 32'(i));
    end
    step();
    bus.wb_en = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_opA", bus.out_opA, 32'd0);
    check("rst_opB", bus.out_opB, 32'd0);
    check("rst_rn", 32'(bus.out_rn), 32'd0);
    check("rst_rm", 32'(bus.out_rm), 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    step();
    reset = 1'b0;

    vecs[0] = '{4'd3,  4'd4,  32'h100, 1'b0, 4'd0,  32'h0,  32'h11, 32'h22};
    vecs[1] = '{4'd3,  4'd3,  32'h104, 1'b1, 4'd3,  32'hAA, 32'hAA, 32'hAA};
    vecs[2] = '{4'd0,  4'd5,  32'h108, 1'b1, 4'd0,  32'h5,  32'h5,  32'hA000_0005};
    vecs[3] = '{4'd0,  4'd3,  32'h10C, 1'b0, 4'd0,  32'h0,  32'h5,  32'hAA};
`ifdef OPFETCH_PC_READ_EN
    vecs[4] = '{4'd15, 4'd1, 32'hFFFF_FFFC, 1'b1, 4'd15, 32'h77, 32'h4, 32'hA000_0001};
    vecs[6] = '{4'd15, 4'd15, 32'h300, 1'b0, 4'd0, 32'h0, 32'h308, 32'h308};
`else
    vecs[4] = '{4'd15, 4'd1, 32'hFFFF_FFFC, 1'b1, 4'd15, 32'h77, 32'h77, 32'hA000_0001};
    vecs[6] = '{4'd15, 4'd15, 32'h300, 1'b0, 4'd0, 32'h0, 32'h77, 32'h77};
`endif
    vecs[5] = '{4'd7,  4'd8,  32'h200, 1'b1, 4'd8,  32'h88, 32'hA000_0007, 32'h88};
    vecs[7] = '{4'd2,  4'd6,  32'h304, 1'b1, 4'd9,  32'h99, 32'hA000_0002, 32'hA000_0006};

    // Back-to-back stream with write-backs landing in each issue cycle
    bus.out_ready = 1'b1;
    c0 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) c0 = cyc;
      bus.in_valid = 1'b1;
      bus.in_rn = vecs[k].rn; bus.in_rm = vecs[k].rm; bus.in_pc = vecs[k].pc;
      bus.wb_en = vecs[k].wb_en; bus.wb_reg = vecs[k].wb_reg; bus.wb_data = vecs[k].wb_data;
      #1;
      check("in_ready_b2b", 32'(bus.in_ready), 32'd1);
      push(vecs[k].rn, vecs[k].rm, vecs[k].pc, vecs[k].exp_a, vecs[k].exp_b);
    end
    step();
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    drain("b2b_drain");
    check("b2b_count", 32'(out_cyc.size()), 32'd8);
    if (out_cyc.size() == 8) begin
      check("b2b_latency", 32'(out_cyc[0] - c0), 32'd2);
      check("b2b_consecutive", 32'(out_cyc[7] - out_cyc[0]), 32'd7);
    end

    // S2 and S1 both stalled; r4 written during the hold
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b1; bus.in_rn = 4'd3; bus.in_rm = 4'd4; bus.in_pc = 32'h400;
    #1; check("stall_accept_x", 32'(bus.in_ready), 32'd1);
    push(4'd3, 4'd4, 32'h400, 32'hAA, 32'h55);
    step();
    bus.in_rn = 4'd4; bus.in_rm = 4'd3; bus.in_pc = 32'h404;
    #1; check("stall_accept_y", 32'(bus.in_ready), 32'd1);
    push(4'd4, 4'd3, 32'h404, 32'h55, 32'hAA);
    step();
    bus.in_valid = 1'b0;
    #1;
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.wb_en = 1'b1; bus.wb_reg = 4'd4; bus.wb_data = 32'h55;
    step();
    bus.wb_en = 1'b0;
    #1;
    check("snoop_opB", bus.out_opB, 32'h55);
    check("snoop_opA", bus.out_opA, 32'hAA);
    check("snoop_pc", bus.out_pc, 32'h400);
    step();
    bus.out_ready = 1'b1;
    drain("stall_drain");

    // Reset with S1 and S2 both occupied
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b1; bus.in_rn = 4'd1; bus.in_rm = 4'd2; bus.in_pc = 32'h600;
    step();
    bus.in_rn = 4'd5; bus.in_rm = 4'd6; bus.in_pc = 32'h604;
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_opA", bus.out_opA, 32'd0);
    check("mid_rst_opB", bus.out_opB, 32'd0);
    check("mid_rst_pc", bus.out_pc, 32'd0);
    check("mid_rst_rn_rm", {24'd0, bus.out_rn, bus.out_rm}, 32'd0);
    step();
    bus.in_valid = 1'b1; bus.in_rn = 4'd3; bus.in_rm = 4'd4; bus.in_pc = 32'h500;
    #1; check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    push(4'd3, 4'd4, 32'h500, 32'hAA, 32'h55);
    step();
    bus.in_valid = 1'b0;
    drain("post_rst_drain");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
